// File: rtl/defines.sv
// Shared JTAG definitions.
// Used by the host model and the device-side TAP.
package defines;

  typedef enum logic [3:0] {
    JTAG_RESET,
    JTAG_IDLE,
    JTAG_SELECT_DR,
    JTAG_CAPTURE_DR,
    JTAG_SHIFT_DR,
    JTAG_EXIT1_DR,
    JTAG_PAUSE_DR,
    JTAG_EXIT2_DR,
    JTAG_UPDATE_DR,
    JTAG_SELECT_IR,
    JTAG_CAPTURE_IR,
    JTAG_SHIFT_IR,
    JTAG_EXIT1_IR,
    JTAG_PAUSE_IR,
    JTAG_EXIT2_IR,
    JTAG_UPDATE_IR
  } jtag_state_t;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a bundle of async inputs.
// Each bit resets to its own idle level.
module synchronizer #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_STATE;
      q    <= RESET_STATE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_tap_sampled.sv
// Oversampled IEEE 1149.1 TAP controller with IR.
// DR lives downstream, driven by one-clk strobes.
module jtag_tap_sampled
  import defines::*;
#(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0]
    INSTRUCTION_RESET = 4'b0001
) (
  input  logic clk,
  input  logic reset,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdo,
  input  logic jtag_trst_n,
  output logic jtag_tdi,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic capture_dr,
  output logic shift_dr,
  output logic data_shift_in,
  input  logic data_shift_out,
  output logic update_dr,
  output logic update_ir
);

  localparam int W = INSTRUCTION_WIDTH;
  localparam logic [W-1:0] IR_CAPTURE = W'(2'b01);

  logic [3:0] pins_s;
  logic tck_s, tms_s, tdo_s, trst_n_s;
  logic tck_prev, rise, fall;
  logic [W-1:0] ir_shift;
  jtag_state_t state, state_next;

  // TRST_N idles high, so its synchronizer bit resets to 1
  synchronizer #(
    .WIDTH(4),
    .RESET_STATE(4'b1000)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({jtag_trst_n, jtag_tdo, jtag_tms, jtag_tck}),
    .q    (pins_s)
  );

  assign tck_s    = pins_s[0];
  assign tms_s    = pins_s[1];
  assign tdo_s    = pins_s[2];
  assign trst_n_s = pins_s[3];

  assign rise = tck_s & ~tck_prev;
  assign fall = ~tck_s & tck_prev;

  always_comb begin
    state_next = state;
    unique case (state)
      JTAG_RESET:
        state_next = tms_s ? JTAG_RESET : JTAG_IDLE;
      JTAG_IDLE:
        state_next = tms_s ? JTAG_SELECT_DR : JTAG_IDLE;
      JTAG_SELECT_DR:
        state_next = tms_s ? JTAG_SELECT_IR : JTAG_CAPTURE_DR;
      JTAG_CAPTURE_DR:
        state_next = tms_s ? JTAG_EXIT1_DR : JTAG_SHIFT_DR;
      JTAG_SHIFT_DR:
        state_next = tms_s ? JTAG_EXIT1_DR : JTAG_SHIFT_DR;
      JTAG_EXIT1_DR:
        state_next = tms_s ? JTAG_UPDATE_DR : JTAG_PAUSE_DR;
      JTAG_PAUSE_DR:
        state_next = tms_s ? JTAG_EXIT2_DR : JTAG_PAUSE_DR;
      JTAG_EXIT2_DR:
        state_next = tms_s ? JTAG_UPDATE_DR : JTAG_SHIFT_DR;
      JTAG_UPDATE_DR:
        state_next = tms_s ? JTAG_SELECT_DR : JTAG_IDLE;
      JTAG_SELECT_IR:
        state_next = tms_s ? JTAG_RESET : JTAG_CAPTURE_IR;
      JTAG_CAPTURE_IR:
        state_next = tms_s ? JTAG_EXIT1_IR : JTAG_SHIFT_IR;
      JTAG_SHIFT_IR:
        state_next = tms_s ? JTAG_EXIT1_IR : JTAG_SHIFT_IR;
      JTAG_EXIT1_IR:
        state_next = tms_s ? JTAG_UPDATE_IR : JTAG_PAUSE_IR;
      JTAG_PAUSE_IR:
        state_next = tms_s ? JTAG_EXIT2_IR : JTAG_PAUSE_IR;
      JTAG_EXIT2_IR:
        state_next = tms_s ? JTAG_UPDATE_IR : JTAG_SHIFT_IR;
      JTAG_UPDATE_IR:
        state_next = tms_s ? JTAG_SELECT_DR : JTAG_IDLE;
      default:
        state_next = JTAG_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= JTAG_RESET;
      instruction   <= INSTRUCTION_RESET;
      ir_shift      <= '0;
      jtag_tdi      <= 1'b0;
      tck_prev      <= 1'b0;
      capture_dr    <= 1'b0;
      shift_dr      <= 1'b0;
      data_shift_in <= 1'b0;
      update_dr     <= 1'b0;
      update_ir     <= 1'b0;
    end else begin
      tck_prev   <= tck_s;
      capture_dr <= 1'b0;
      shift_dr   <= 1'b0;
      update_dr  <= 1'b0;
      update_ir  <= 1'b0;
      if (!trst_n_s) begin
        state       <= JTAG_RESET;
        instruction <= INSTRUCTION_RESET;
      end else if (rise) begin
        state <= state_next;
        // actions belong to the state being left
        unique case (state)
          JTAG_RESET:
            instruction <= INSTRUCTION_RESET;
          JTAG_CAPTURE_IR:
            ir_shift <= IR_CAPTURE;
          JTAG_SHIFT_IR:
            ir_shift <= {tdo_s, ir_shift[W-1:1]};
          JTAG_UPDATE_IR: begin
            instruction <= ir_shift;
            update_ir   <= 1'b1;
          end
          JTAG_CAPTURE_DR:
            capture_dr <= 1'b1;
          JTAG_SHIFT_DR: begin
            shift_dr      <= 1'b1;
            data_shift_in <= tdo_s;
          end
          JTAG_UPDATE_DR:
            update_dr <= 1'b1;
          default: ;
        endcase
      end else if (fall) begin
        unique case (state)
          JTAG_SHIFT_IR: jtag_tdi <= ir_shift[0];
          JTAG_SHIFT_DR: jtag_tdi <= data_shift_out;
          default:       jtag_tdi <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled.
// Drives TCK/TMS pins, models a 32-bit DR and a reference TAP.
module tb_jtag_tap_sampled;
  import defines::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic jtag_tck = 1'b0;
  logic jtag_tms = 1'b1;
  logic jtag_tdo = 1'b0;
  logic jtag_trst_n = 1'b1;
  logic jtag_tdi;
  logic [3:0] instruction;
  logic capture_dr, shift_dr, data_shift_in;
  logic data_shift_out, update_dr, update_ir;

  int n_cmp = 0;
  int n_err = 0;
  int n_cap = 0, n_shift = 0, n_upd = 0, n_uir = 0;
  logic [31:0] dr_model = '0;

  always #5 clk = ~clk;

  jtag_tap_sampled dut (
    .clk           (clk),
    .reset         (reset),
    .jtag_tck      (jtag_tck),
    .jtag_tms      (jtag_tms),
    .jtag_tdo      (jtag_tdo),
    .jtag_trst_n   (jtag_trst_n),
    .jtag_tdi      (jtag_tdi),
    .instruction   (instruction),
    .capture_dr    (capture_dr),
    .shift_dr      (shift_dr),
    .data_shift_in (data_shift_in),
    .data_shift_out(data_shift_out),
    .update_dr     (update_dr),
    .update_ir     (update_ir)
  );

  assign data_shift_out = dr_model[0];

  always @(posedge clk) begin
    if (capture_dr) dr_model <= 32'hDEADBEEF;
    else if (shift_dr) dr_model <= {data_shift_in, dr_model[31:1]};
    if (capture_dr) n_cap <= n_cap + 1;
    if (shift_dr) n_shift <= n_shift + 1;
    if (update_dr) n_upd <= n_upd + 1;
    if (update_ir) n_uir <= n_uir + 1;
  end

  function automatic jtag_state_t ref_next(jtag_state_t s, logic t);
    case (s)
      JTAG_RESET:      return t ? JTAG_RESET : JTAG_IDLE;
      JTAG_IDLE:       return t ? JTAG_SELECT_DR : JTAG_IDLE;
      JTAG_SELECT_DR:  return t ? JTAG_SELECT_IR : JTAG_CAPTURE_DR;
      JTAG_CAPTURE_DR: return t ? JTAG_EXIT1_DR : JTAG_SHIFT_DR;
      JTAG_SHIFT_DR:   return t ? JTAG_EXIT1_DR : JTAG_SHIFT_DR;
      JTAG_EXIT1_DR:   return t ? JTAG_UPDATE_DR : JTAG_PAUSE_DR;
      JTAG_PAUSE_DR:   return t ? JTAG_EXIT2_DR : JTAG_PAUSE_DR;
      JTAG_EXIT2_DR:   return t ? JTAG_UPDATE_DR : JTAG_SHIFT_DR;
      JTAG_UPDATE_DR:  return t ? JTAG_SELECT_DR : JTAG_IDLE;
      JTAG_SELECT_IR:  return t ? JTAG_RESET : JTAG_CAPTURE_IR;
      JTAG_CAPTURE_IR: return t ? JTAG_EXIT1_IR : JTAG_SHIFT_IR;
      JTAG_SHIFT_IR:   return t ? JTAG_EXIT1_IR : JTAG_SHIFT_IR;
      JTAG_EXIT1_IR:   return t ? JTAG_UPDATE_IR : JTAG_PAUSE_IR;
      JTAG_PAUSE_IR:   return t ? JTAG_EXIT2_IR : JTAG_PAUSE_IR;
      JTAG_EXIT2_IR:   return t ? JTAG_UPDATE_IR : JTAG_SHIFT_IR;
      default:         return t ? JTAG_SELECT_DR : JTAG_IDLE;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one TCK period; returns the host-side bit present before the rise
  task automatic tck_cycle(input logic tms, input logic tdo,
                           input int half, output logic seen);
    seen = jtag_tdi;
    jtag_tms = tms;
    jtag_tdo = tdo;
    jtag_tck = 1'b1;
    repeat (half) @(posedge clk);
    #1;
    jtag_tck = 1'b0;
    repeat (half) @(posedge clk);
    #1;
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int n);
    logic b;
    for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, 8, b);
  endtask

  initial begin
    logic b;
    logic [3:0] ir_seen;
    logic [31:0] dr_seen;
    logic [31:0] dr_in;
    int c0, s0, u0, ui0;
    jtag_state_t ms;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dut.state), 32'(JTAG_RESET));
    chk("rst_instr", 32'(instruction), 32'h1);
    chk("rst_tdi", 32'(jtag_tdi), 32'h0);
    chk("rst_strobes",
        32'({capture_dr, shift_dr, update_dr, update_ir}), 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 5 x TMS=1 then TMS=0 lands in IDLE
    tms_seq(8'b0001_1111, 6);
    chk("idle_state", 32'(dut.state), 32'(JTAG_IDLE));
    chk("idle_instr", 32'(instruction), 32'h1);
    chk("idle_strobes", 32'(n_cap + n_shift + n_upd + n_uir), 32'h0);

    // IR scan of 4'b1010
    tms_seq(8'b0000_0011, 4);
    chk("sir_state", 32'(dut.state), 32'(JTAG_SHIFT_IR));
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, 1'(4'b1010 >> i), 8, b);
      ir_seen[i] = b;
    end
    chk("ir_tdi", 32'(ir_seen), 32'h1);
    tms_seq(8'b0000_0001, 2);
    chk("ir_update_cnt", 32'(n_uir), 32'h1);
    chk("ir_instr", 32'(instruction), 32'hA);
    chk("ir_idle", 32'(dut.state), 32'(JTAG_IDLE));

    // 32-bit DR scan with a pause after bit 13
    c0 = n_cap; s0 = n_shift; u0 = n_upd;
    dr_in = 32'h12345678;
    tms_seq(8'b0000_0001, 3);
    for (int i = 0; i < 32; i++) begin
      tck_cycle(i == 13 || i == 31, dr_in[i], 8, b);
      dr_seen[i] = b;
      if (i == 13) begin
        tms_seq(8'b0000_0100, 4);
        chk("dr_resume", 32'(dut.state), 32'(JTAG_SHIFT_DR));
      end
    end
    tms_seq(8'b0000_0001, 2);
    chk("dr_tdi", dr_seen, 32'hDEADBEEF);
    chk("dr_model", dr_model, 32'h12345678);
    chk("dr_cap_cnt", 32'(n_cap - c0), 32'd1);
    chk("dr_shift_cnt", 32'(n_shift - s0), 32'd32);
    chk("dr_upd_cnt", 32'(n_upd - u0), 32'd1);

    // TRST_N pulse during SHIFT_DR
    u0 = n_upd;
    tms_seq(8'b0000_0001, 3);
    tms_seq(8'b0000_0000, 2);
    chk("trst_pre", 32'(dut.state), 32'(JTAG_SHIFT_DR));
    @(posedge clk);
    #1;
    jtag_trst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    jtag_trst_n = 1'b1;
    chk("trst_state", 32'(dut.state), 32'(JTAG_RESET));
    chk("trst_instr", 32'(instruction), 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("trst_no_upd", 32'(n_upd - u0), 32'd0);
    chk("trst_hold", 32'(dut.state), 32'(JTAG_RESET));

    // reset in the middle of SHIFT_IR
    ui0 = n_uir;
    tms_seq(8'b0000_0110, 5);
    tck_cycle(1'b0, 1'b1, 8, b);
    tck_cycle(1'b0, 1'b1, 8, b);
    chk("rsir_pre", 32'(dut.state), 32'(JTAG_SHIFT_IR));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rsir_state", 32'(dut.state), 32'(JTAG_RESET));
    chk("rsir_instr", 32'(instruction), 32'h1);
    chk("rsir_irs", 32'(dut.ir_shift), 32'h0);
    chk("rsir_tdi", 32'(jtag_tdi), 32'h0);
    chk("rsir_strobes",
        32'({capture_dr, shift_dr, update_dr, update_ir}), 32'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rsir_no_uir", 32'(n_uir - ui0), 32'd0);

    // random TMS walk at the minimum half-period
    ms = JTAG_RESET;
    for (int i = 0; i < 80; i++) begin
      logic t;
      t = 1'($urandom_range(0, 1));
      ms = ref_next(ms, t);
      tck_cycle(t, 1'($urandom_range(0, 1)), 6, b);
      chk($sformatf("walk%0d", i), 32'(dut.state), 32'(ms));
    end
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 6, b);
    chk("walk_reset", 32'(dut.state), 32'(JTAG_RESET));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
